// File: rtl/interrupt_example_cpu_jtag_scan_master.sv
// Virtual-JTAG scan initiator: one command runs UIR, CDR, SDR (DR_WIDTH bits) and UDR,
// then returns the captured tdo word on a one-cycle rsp_valid pulse.
//
// state  | meaning
// S_IDLE | run-test-idle, cmd_ready high, waiting for a command
// S_UIR  | one tck period with vji_uir high, ir_in already loaded
// S_CDR  | one tck period with vji_cdr high
// S_SDR  | DR_WIDTH tck periods, one bit shifted per period
// S_UDR  | one tck period with vji_udr high
// S_RSP  | single cycle: rsp_valid pulse, captured word presented
module interrupt_example_cpu_jtag_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int PW = $clog2(2*TCK_DIV);
  localparam logic [PW-1:0] PH_LAST     = PW'(2*TCK_DIV-1);
  localparam logic [PW-1:0] PH_HI       = PW'(TCK_DIV);
  localparam logic [PW-1:0] PH_HI_FIRST = PW'(TCK_DIV-1);
  localparam logic [5:0]    BIT_LAST    = 6'(DR_WIDTH-1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RSP
  } state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       ph_cnt;
  logic [5:0]          bit_cnt;
  logic [DR_WIDTH-1:0] tx_sr;
  logic [DR_WIDTH-1:0] rx_sr;
  logic                fire;
  logic                in_scan;
  logic                period_end;
  logic                hi_first;
  logic                last_bit;

  // ph_cnt counts down through one tck period; tck is high in its lower half
  always_comb begin
    state_nxt  = state;
    in_scan    = (state == S_UIR) || (state == S_CDR) || (state == S_SDR) || (state == S_UDR);
    period_end = (ph_cnt == '0);
    hi_first   = (ph_cnt == PH_HI_FIRST);
    last_bit   = (bit_cnt == BIT_LAST);
    cmd_ready  = (state == S_IDLE) && !reset;
    fire       = cmd_valid && cmd_ready;
    rsp_valid  = (state == S_RSP);
    vji_rti    = (state == S_IDLE);
    vji_uir    = (state == S_UIR);
    vji_cdr    = (state == S_CDR);
    vji_sdr    = (state == S_SDR);
    vji_udr    = (state == S_UDR);
    vji_tck    = in_scan && (ph_cnt < PH_HI);
    vji_tdi    = (state == S_SDR) ? tx_sr[0] : 1'b0;

    case (state)
      S_IDLE:  if (fire) state_nxt = S_UIR;
      S_UIR:   if (period_end) state_nxt = S_CDR;
      S_CDR:   if (period_end) state_nxt = S_SDR;
      S_SDR:   if (period_end && last_bit) state_nxt = S_UDR;
      S_UDR:   if (period_end) state_nxt = S_RSP;
      S_RSP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ph_cnt    <= PH_LAST;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      vji_ir_in <= '0;
      rsp_dr    <= '0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        tx_sr     <= cmd_dr;
        vji_ir_in <= cmd_ir;
        bit_cnt   <= '0;
        ph_cnt    <= PH_LAST;
      end else if (in_scan) begin
        ph_cnt <= period_end ? PH_LAST : ph_cnt - PW'(1);
        if (state == S_SDR) begin
          // with TCK_DIV=1 the sample and the bit advance land on the same cycle
          if (hi_first) rx_sr <= {vji_tdo, rx_sr[DR_WIDTH-1:1]};
          if (period_end) begin
            tx_sr   <= tx_sr >> 1;
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
      end
      if ((state == S_UDR) && period_end) rsp_dr <= rx_sr;
    end
  end

endmodule

// File: tb/tb_interrupt_example_cpu_jtag_scan_master.sv
// Bench for the virtual-JTAG scan master: cycle-indexed model of one scan plus directed
// loopback, constant-tdo, abort and back-to-back checks.
module tb_interrupt_example_cpu_jtag_scan_master;
  localparam int DR   = 38;
  localparam int IR   = 2;
  localparam int TD   = 2;
  localparam int TD1  = 1;
  localparam int LAST = 1 + (DR+3)*2*TD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, rsp_valid;
  logic [IR-1:0] cmd_ir, vji_ir_in;
  logic [DR-1:0] cmd_dr, rsp_dr;
  logic          vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  logic          cmd_valid1, cmd_ready1, rsp_valid1;
  logic [IR-1:0] cmd_ir1, vji_ir_in1;
  logic [DR-1:0] cmd_dr1, rsp_dr1;
  logic          tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;

  int   mode;
  logic m_bit0;
  assign vji_tdo = (mode == 0) ? vji_tdi : (mode == 1) ? 1'b1 : m_bit0;

  interrupt_example_cpu_jtag_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_dr(rsp_dr),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
    .vji_rti(vji_rti));

  interrupt_example_cpu_jtag_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(TD1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_ir(cmd_ir1), .cmd_dr(cmd_dr1), .rsp_valid(rsp_valid1), .rsp_dr(rsp_dr1),
    .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdi1), .vji_ir_in(vji_ir_in1),
    .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1));

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: cycle c after the transfer selects tck period k = (c-1)/(2*TD);
  // period 0 is UIR, 1 is CDR, 2..DR+1 are SDR bits, DR+2 is UDR, cycle LAST is the response.
  bit            m_act = 0, pend_rst = 0, pend_xfer = 0, chk_en = 0;
  int            c = 0;
  logic [DR-1:0] m_dr = '0, m_rsp = '0, nx_dr = '0;
  logic [IR-1:0] m_ir = '0, nx_ir = '0;

  initial m_bit0 = 1'b0;

  always @(negedge clk) begin
    int k, w;
    logic e_rdy, e_rv, e_tck, e_tdi, e_uir, e_cdr, e_sdr, e_udr, e_rti;
    if (pend_rst) begin
      m_act = 0; m_rsp = '0; m_ir = '0; chk_en = 1;
    end else if (pend_xfer) begin
      m_act = 1; c = 1; m_dr = nx_dr; m_ir = nx_ir;
    end else if (m_act) begin
      c++;
      if (c > LAST) m_act = 0;
    end
    {e_rdy, e_rv, e_tck, e_tdi, e_uir, e_cdr, e_sdr, e_udr, e_rti} = '0;
    if (!m_act) begin
      e_rti = 1'b1;
      e_rdy = !reset;
    end else if (c == LAST) begin
      e_rv = 1'b1;
      for (int i = 0; i < DR; i++)
        m_rsp[i] = (mode == 0) ? m_dr[i] : (mode == 1) ? 1'b1 : (i == 0);
    end else begin
      k = (c-1) / (2*TD);
      w = (c-1) % (2*TD);
      e_tck = (w >= TD);
      e_uir = (k == 0);
      e_cdr = (k == 1);
      e_sdr = (k >= 2) && (k < DR+2);
      e_udr = (k == DR+2);
      if (e_sdr) e_tdi = m_dr[k-2];
    end
    if (chk_en)
      check($sformatf("model c=%0d act=%0d", c, m_act),
            {cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr,
             vji_rti, vji_ir_in, rsp_dr},
            {e_rdy, e_rv, e_tck, e_tdi, e_uir, e_cdr, e_sdr, e_udr, e_rti, m_ir, m_rsp});
    m_bit0    = m_act && (c < LAST) && (((c-1) / (2*TD)) == 2);
    pend_rst  = reset;
    pend_xfer = cmd_valid && !m_act && !reset;
    nx_dr     = cmd_dr;
    nx_ir     = cmd_ir;
  end

  int n_uir, n_cdr, n_sdr, n_udr, n_rise, n_rti0, n_irbad;

  task automatic run_cmd(input logic [IR-1:0] ir, input logic [DR-1:0] dr,
                         output int rc, output logic [DR-1:0] got);
    int w;
    bit prev;
    w = 0;
    prev = 0;
    cmd_valid = 1'b1; cmd_ir = ir; cmd_dr = dr;
    while (!cmd_ready && w < 50) begin cyc(); w++; end
    cyc();
    cmd_valid = 1'b0; cmd_ir = ~ir; cmd_dr = ~dr;
    {n_uir, n_cdr, n_sdr, n_udr, n_rise, n_rti0, n_irbad} = '0;
    rc = 1;
    while (1) begin
      if (vji_uir) n_uir++;
      if (vji_cdr) n_cdr++;
      if (vji_sdr) n_sdr++;
      if (vji_udr) n_udr++;
      if (vji_sdr && vji_tck && !prev) n_rise++;
      if (!vji_rti) n_rti0++;
      if (vji_ir_in !== ir) n_irbad++;
      prev = vji_tck;
      if (rsp_valid || rc >= 400) break;
      cyc();
      rc++;
    end
    got = rsp_dr;
    cyc();
    check("rsp_valid single pulse", rsp_valid, 1'b0);
  endtask

  initial begin
    int rc, cnt, nx, nrv, last, bad_gap, bad_rsp;
    logic [DR-1:0] got;
    mode = 0;
    cmd_valid = 0; cmd_ir = '0; cmd_dr = '0;
    cmd_valid1 = 0; cmd_ir1 = '0; cmd_dr1 = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset rti", vji_rti, 1'b1);
    check("reset tck", vji_tck, 1'b0);
    check("reset flags", {vji_uir, vji_cdr, vji_sdr, vji_udr}, 4'b0000);
    check("reset cmd_ready", cmd_ready, 1'b0);
    check("reset rsp_dr", rsp_dr, 38'h0);
    reset = 1'b0;
    cyc();
    check("ready after release", cmd_ready, 1'b1);

    mode = 0;
    run_cmd(2'b01, 38'h2A_5A5A_5A5A, rc, got);
    check("loopback rsp cycle", rc, 165);
    check("loopback rsp_dr", got, 38'h2A_5A5A_5A5A);
    check("uir cycles", n_uir, 4);
    check("cdr cycles", n_cdr, 4);
    check("udr cycles", n_udr, 4);
    check("sdr cycles", n_sdr, 152);
    check("sdr tck rises", n_rise, 38);
    check("rti low cycles", n_rti0, 165);
    check("ir_in held", n_irbad, 0);

    mode = 1;
    run_cmd(2'b10, 38'h0, rc, got);
    check("tdo=1 rsp_dr", got, 38'h3F_FFFF_FFFF);
    mode = 2;
    run_cmd(2'b11, 38'h15, rc, got);
    check("onehot tdo rsp_dr", got, 38'h1);
    mode = 0;
    repeat (2) cyc();

    cmd_valid = 1'b1; cmd_ir = 2'b10; cmd_dr = 38'h0C_3C3C_0F0F;
    cyc();
    cmd_valid = 1'b0;
    repeat (49) cyc();
    check("abort in sdr", vji_sdr, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("abort rti", vji_rti, 1'b1);
    check("abort flags/tck/tdi", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_tck, vji_tdi}, 6'b0);
    check("abort ir_in", vji_ir_in, 2'b00);
    check("abort rsp_dr", rsp_dr, 38'h0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) cnt++;
      cyc();
    end
    check("abort no rsp_valid", cnt, 0);
    run_cmd(2'b01, 38'h15_A5A5_C3C3, rc, got);
    check("post-abort rsp cycle", rc, 165);
    check("post-abort rsp_dr", got, 38'h15_A5A5_C3C3);

    cmd_dr1 = 38'h0F_0123_4567; cmd_ir1 = 2'b10; cmd_valid1 = 1'b1;
    nx = 0; nrv = 0; last = -1; bad_gap = 0; bad_rsp = 0;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready1) begin
        if (last >= 0 && i - last != 84) bad_gap++;
        last = i;
        nx++;
      end
      if (rsp_valid1) begin
        nrv++;
        if (rsp_dr1 !== 38'h0F_0123_4567) bad_rsp++;
      end
      cyc();
    end
    cmd_valid1 = 1'b0;
    check("busy transfers", nx, 4);
    check("busy spacing", bad_gap, 0);
    check("busy responses", nrv, 3);
    check("busy rsp_dr", bad_rsp, 0);
    repeat (100) cyc();
    check("busy drained idle", rti1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
